fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 127 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the async FIFO's latent read port into a first-word-fall-through
// valid/ready stream. Define FIFO_RD_STREAM_PERF_EN to add beat_cnt/stall_cnt counters.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
    input  logic                           flush,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level
`ifdef FIFO_RD_STREAM_PERF_EN
    ,
    output logic [31:0]                    beat_cnt,
    output logic [31:0]                    stall_cnt
`endif
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + RD_LATENCY + 1);

    if (RD_LATENCY < 1 || BUF_DEPTH < RD_LATENCY + 2) begin : g_bad_params
        $error("fifo_rd_stream: need RD_LATENCY >= 1 and BUF_DEPTH >= RD_LATENCY+2");
    end

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [RD_LATENCY-1:0] inflight;
    logic [RD_LATENCY-1:0] kill;
    logic [OW-1:0]         occupancy;
    logic                  issue;
    logic                  ret_ok;
    logic                  pop;

    function automatic logic [OW-1:0] popcount(input logic [RD_LATENCY-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit rule: every outstanding read already owns a buffer slot, so the
    // buffer cannot overflow and rd_en never depends on m_ready.
    assign occupancy  = OW'(count) + popcount(inflight);
    assign issue      = rst_n && !fifo_empty && !flush && (occupancy < OW'(BUF_DEPTH));
    assign fifo_rd_en = issue;

    // The MSB of inflight marks the cycle a read's data is on fifo_rd_data.
    assign ret_ok  = inflight[RD_LATENCY-1] && !kill[RD_LATENCY-1] && !flush;
    assign m_valid = (count != '0);
    assign m_data  = buf_mem[head];
    assign pop     = m_valid && m_ready;
    assign level   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            kill     <= '0;
        end else begin
            inflight <= (inflight << 1) | RD_LATENCY'(issue);
            // Kill bits travel alongside the in-flight bits they shadow.
            kill     <= (kill | (flush ? inflight : '0)) << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (ret_ok) tail <= wrap_inc(tail);
            if (pop)    head <= wrap_inc(head);
            case ({ret_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entries are cleared on reset so m_data reads 0 and no stale word survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (ret_ok) begin
            buf_mem[tail] <= fifo_rd_data;
        end
    end

`ifdef FIFO_RD_STREAM_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop)                  beat_cnt  <= beat_cnt + 32'd1;
            if (m_valid && !m_ready)  stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: three instances (L2/D4, L1/D3, L2/D5) fed by queue-based FIFO
// models; a stream scoreboard plus directed cycle checks. Perf checks need FIFO_RD_STREAM_PERF_EN.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        empty0 = 1'b1, empty1 = 1'b1, empty2 = 1'b1;
    logic        rd_en0, rd_en1, rd_en2;
    logic [31:0] rd_data0, rd_data1, rd_data2;
    logic        flush0, flush1, flush2;
    logic        valid0, valid1, valid2;
    logic        ready0, ready1, ready2;
    logic [31:0] data0, data1, data2;
    logic [2:0]  level0;
    logic [1:0]  level1;
    logic [2:0]  level2;
`ifdef FIFO_RD_STREAM_PERF_EN
    logic [31:0] beat0, stall0, beat1, stall1, beat2, stall2;
`endif

    int checks = 0;
    int errors = 0;
    int beats0 = 0, beats1 = 0, beats2 = 0;

    logic [31:0] fq0[$], fq1[$], fq2[$];
    logic [31:0] exp_q0[$], exp_q1[$], exp_q2[$];
    logic [31:0] p0a, p0b, p1a, p2a, p2b;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(2), .BUF_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty0), .fifo_rd_en(rd_en0),
        .fifo_rd_data(rd_data0), .flush(flush0), .m_valid(valid0), .m_ready(ready0),
        .m_data(data0), .level(level0)
`ifdef FIFO_RD_STREAM_PERF_EN
        , .beat_cnt(beat0), .stall_cnt(stall0)
`endif
    );

    fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(1), .BUF_DEPTH(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty1), .fifo_rd_en(rd_en1),
        .fifo_rd_data(rd_data1), .flush(flush1), .m_valid(valid1), .m_ready(ready1),
        .m_data(data1), .level(level1)
`ifdef FIFO_RD_STREAM_PERF_EN
        , .beat_cnt(beat1), .stall_cnt(stall1)
`endif
    );

    fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(2), .BUF_DEPTH(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty2), .fifo_rd_en(rd_en2),
        .fifo_rd_data(rd_data2), .flush(flush2), .m_valid(valid2), .m_ready(ready2),
        .m_data(data2), .level(level2)
`ifdef FIFO_RD_STREAM_PERF_EN
        , .beat_cnt(beat2), .stall_cnt(stall2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // FIFO models: registered empty, read data appears RD_LATENCY cycles after the request,
    // junk otherwise. Every word taken from a FIFO becomes an expected stream word.
    assign rd_data0 = p0b;
    assign rd_data1 = p1a;
    assign rd_data2 = p2b;

    always @(posedge clk) begin
        logic [31:0] w0, w1, w2;
        w0 = $urandom;
        w1 = $urandom;
        w2 = $urandom;
        if (rd_en0 && fq0.size() != 0) begin w0 = fq0.pop_front(); exp_q0.push_back(w0); end
        if (rd_en1 && fq1.size() != 0) begin w1 = fq1.pop_front(); exp_q1.push_back(w1); end
        if (rd_en2 && fq2.size() != 0) begin w2 = fq2.pop_front(); exp_q2.push_back(w2); end
        p0a <= w0; p0b <= p0a;
        p1a <= w1;
        p2a <= w2; p2b <= p2a;
        empty0 <= (fq0.size() == 0);
        empty1 <= (fq1.size() == 0);
        empty2 <= (fq2.size() == 0);
    end

    // Stream monitor: in-order delivery, flush/reset discard what is outstanding.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
        end else begin
            chk("rd_en_while_empty0", 32'(rd_en0 & empty0), 32'd0);
            chk("rd_en_while_empty1", 32'(rd_en1 & empty1), 32'd0);
            chk("rd_en_while_empty2", 32'(rd_en2 & empty2), 32'd0);
            chk("level_bound0", 32'(level0 <= 3'd4), 32'd1);
            chk("level_bound1", 32'(level1 <= 2'd3), 32'd1);
            chk("level_bound2", 32'(level2 <= 3'd5), 32'd1);
            if (valid0 && ready0) begin
                chk("beat_expected0", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) chk("beat_data0", data0, exp_q0.pop_front());
                beats0++;
            end
            if (valid1 && ready1) begin
                chk("beat_expected1", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) chk("beat_data1", data1, exp_q1.pop_front());
                beats1++;
            end
            if (valid2 && ready2) begin
                chk("beat_expected2", 32'(exp_q2.size() != 0), 32'd1);
                if (exp_q2.size() != 0) chk("beat_data2", data2, exp_q2.pop_front());
                beats2++;
            end
            if (flush0) exp_q0.delete();
            if (flush1) exp_q1.delete();
            if (flush2) exp_q2.delete();
        end
    end

    initial begin
        int b;
        int k;
        int pulses;
        flush0 = 0; flush1 = 0; flush2 = 0;
        ready0 = 0; ready1 = 0; ready2 = 0;
        rst_n = 0;
        tick();
        tick();

        // Reset state of all instances
        sample();
        chk("rst_valid0", 32'(valid0), 32'd0);
        chk("rst_rd_en0", 32'(rd_en0), 32'd0);
        chk("rst_data0", data0, 32'd0);
        chk("rst_level0", 32'(level0), 32'd0);
        chk("rst_valid1", 32'(valid1), 32'd0);
        chk("rst_level1", 32'(level1), 32'd0);
        chk("rst_valid2", 32'(valid2), 32'd0);
        chk("rst_level2", 32'(level2), 32'd0);

        // Startup latency and gap-free streaming
        ready0 = 1;
        for (int i = 0; i < 8; i++) fq0.push_back(32'h10 + i);
        tick();
        tick();
        rst_n = 1;
        b = beats0;
        for (int c = 0; c < 13; c++) begin
            sample();
            chk("t1_rd_en", 32'(rd_en0), 32'(c < 8));
            chk("t1_valid", 32'(valid0), 32'(c >= 3 && c < 11));
            if (c >= 3 && c < 11) chk("t1_data", data0, 32'(32'h10 + c - 3));
            tick();
        end
        chk("t1_beats", 32'(beats0 - b), 32'd8);
        chk("t1_fifo_drained", 32'(fq0.size()), 32'd0);

        // Backpressure: credit limit, hold, then intact order
        rst_n = 0;
        ready0 = 0;
        for (int i = 0; i < 8; i++) fq0.push_back(32'h10 + i);
        tick();
        tick();
        rst_n = 1;
        b = beats0;
        for (int c = 0; c < 10; c++) begin
            sample();
            chk("t2_rd_en", 32'(rd_en0), 32'(c < 4));
            if (c >= 3) begin
                chk("t2_valid_held", 32'(valid0), 32'd1);
                chk("t2_data_held", data0, 32'h10);
            end
            if (c >= 6) chk("t2_level_full", 32'(level0), 32'd4);
            tick();
        end
        ready0 = 1;
        k = 0;
        while ((beats0 - b) < 8 && k < 40) begin tick(); k++; end
        chk("t2_beats", 32'(beats0 - b), 32'd8);
        chk("t2_sb_empty", 32'(exp_q0.size()), 32'd0);
        chk("t2_fifo_drained", 32'(fq0.size()), 32'd0);

        // Empty boundary: a single word
        rst_n = 0;
        fq0.push_back(32'hAA);
        tick();
        tick();
        rst_n = 1;
        b = beats0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (rd_en0) pulses++;
            chk("t3_valid", 32'(valid0), 32'(c == 3));
            if (c == 3) chk("t3_data", data0, 32'hAA);
            tick();
        end
        chk("t3_rd_pulses", 32'(pulses), 32'd1);
        chk("t3_beats", 32'(beats0 - b), 32'd1);

        // Flush with two reads in flight
        rst_n = 0;
        ready0 = 0;
        fq0.push_back(32'h01);
        fq0.push_back(32'h02);
        fq0.push_back(32'h03);
        tick();
        tick();
        rst_n = 1;
        b = beats0;
        sample(); chk("t4_rd_en_c0", 32'(rd_en0), 32'd1); tick();
        sample(); chk("t4_rd_en_c1", 32'(rd_en0), 32'd1); tick();
        flush0 = 1;
        sample(); chk("t4_rd_en_flush", 32'(rd_en0), 32'd0); tick();
        flush0 = 0;
        for (int c = 3; c < 6; c++) begin
            sample();
            chk("t4_valid_dropped", 32'(valid0), 32'd0);
            chk("t4_level_zero", 32'(level0), 32'd0);
            if (c == 3) chk("t4_rd_en_resume", 32'(rd_en0), 32'd1);
            tick();
        end
        sample();
        chk("t4_valid_next", 32'(valid0), 32'd1);
        chk("t4_data_next", data0, 32'h03);
        chk("t4_level_next", 32'(level0), 32'd1);
        tick();
        ready0 = 1;
        tick();
        tick();
        chk("t4_beats", 32'(beats0 - b), 32'd1);
        chk("t4_sb_empty", 32'(exp_q0.size()), 32'd0);

        // Random backpressure, RD_LATENCY=1, BUF_DEPTH=3
        rst_n = 0;
        for (int i = 0; i < 1000; i++) fq1.push_back($urandom);
        tick();
        tick();
        rst_n = 1;
        b = beats1;
        k = 0;
        while ((beats1 - b) < 1000 && k < 8000) begin
            ready1 = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("t5_beats", 32'(beats1 - b), 32'd1000);
        chk("t5_sb_empty", 32'(exp_q1.size()), 32'd0);
        chk("t5_fifo_drained", 32'(fq1.size()), 32'd0);

        // Async reset with level 3 and two reads in flight (BUF_DEPTH=5)
        rst_n = 0;
        ready2 = 0;
        for (int i = 0; i < 8; i++) fq2.push_back(32'h20 + i);
        tick();
        tick();
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            sample();
            chk("t6_rd_en", 32'(rd_en2), 32'(c < 5));
            if (c == 5) chk("t6_level_pre", 32'(level2), 32'd3);
            if (c < 5) tick();
        end
        rst_n = 0;
        #1;
        chk("t6_valid_async", 32'(valid2), 32'd0);
        chk("t6_level_async", 32'(level2), 32'd0);
        chk("t6_data_async", data2, 32'd0);
        tick();
        tick();
        rst_n = 1;
        ready2 = 1;
        b = beats2;
        k = 0;
        while ((beats2 - b) < 3 && k < 30) begin tick(); k++; end
        chk("t6_beats", 32'(beats2 - b), 32'd3);
        chk("t6_sb_empty", 32'(exp_q2.size()), 32'd0);
        chk("t6_fifo_drained", 32'(fq2.size()), 32'd0);

`ifdef FIFO_RD_STREAM_PERF_EN
        // Perf counters: three stalls, then five beats, then flush
        rst_n = 0;
        ready0 = 0;
        for (int i = 0; i < 5; i++) fq0.push_back(32'h40 + i);
        tick();
        sample();
        chk("t7_beat_rst", beat0, 32'd0);
        chk("t7_stall_rst", stall0, 32'd0);
        tick();
        rst_n = 1;
        b = beats0;
        for (int c = 0; c < 6; c++) tick();
        ready0 = 1;
        k = 0;
        while ((beats0 - b) < 5 && k < 40) begin tick(); k++; end
        tick();
        sample();
        chk("t7_beat_cnt", beat0, 32'd5);
        chk("t7_stall_cnt", stall0, 32'd3);
        tick();
        flush0 = 1;
        tick();
        flush0 = 0;
        sample();
        chk("t7_beat_flush", beat0, 32'd0);
        chk("t7_stall_flush", stall0, 32'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
